// File: rtl/fixed_multiply.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add on magnitudes,
// then round-half-away-from-zero and saturation to D_WIDTH bits.
module fixed_multiply #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [D_WIDTH-1:0] product,
  output logic               overflow,
  output logic               valid_out
);

  localparam int AW  = 2 * D_WIDTH;
  localparam int CW  = $clog2(D_WIDTH + 1);
  localparam int RSH = (Q_BITS > 0) ? Q_BITS - 1 : 0;
  localparam logic [CW-1:0] LAST    = CW'(D_WIDTH);
  localparam logic [AW-1:0] HALF    = (Q_BITS > 0) ? (AW'(1) << RSH) : '0;
  localparam logic [AW-1:0] MAX_POS = {{(D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] MIN_MAG = {{D_WIDTH{1'b0}}, 1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               sign;
  logic [D_WIDTH-1:0] mcand;
  logic [D_WIDTH-1:0] mplier;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      count;
  logic [AW-1:0]      rounded;
  logic [D_WIDTH-1:0] result;
  logic               result_ovf;

  // Unsigned magnitude; the most negative value maps to 2^(D_WIDTH-1) unchanged.
  function automatic logic [D_WIDTH-1:0] magnitude(input logic [D_WIDTH-1:0] v);
    magnitude = v[D_WIDTH-1] ? (~v + {{(D_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; RUN keeps iterating until the counter reaches D_WIDTH
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (valid_in) state_next = RUN;
        else          state_next = IDLE;
      end
      RUN: begin
        if (count < LAST) state_next = RUN;
        else              state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rounding and saturation of the accumulated magnitude
  always_comb begin
    rounded    = (acc + HALF) >> Q_BITS;
    result     = rounded[D_WIDTH-1:0];
    result_ovf = 1'b0;
    if (!sign) begin
      if (rounded > MAX_POS) begin
        result     = MAX_POS[D_WIDTH-1:0];
        result_ovf = 1'b1;
      end else begin
        result = rounded[D_WIDTH-1:0];
      end
    end else begin
      if (rounded > MIN_MAG) begin
        result     = {1'b1, {(D_WIDTH-1){1'b0}}};
        result_ovf = 1'b1;
      end else begin
        // A zero magnitude negates to +0
        result = ~rounded[D_WIDTH-1:0] + {{(D_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Operand capture and shift-add iteration
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            sign   <= a[D_WIDTH-1] ^ b[D_WIDTH-1];
            mcand  <= magnitude(a);
            mplier <= magnitude(b);
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (count < LAST) begin
            if (mplier[0]) acc <= acc + ({{D_WIDTH{1'b0}}, mcand} << count);
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers load on the DONE->IDLE edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      product   <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= (state == DONE);
      if (state == DONE) begin
        product  <= result;
        overflow <= result_ovf;
      end
    end
  end

  assign ready_out = (state == IDLE);

endmodule

// File: tb/tb_fixed_multiply.sv
// Self-checking bench for fixed_multiply (Q_BITS=10, D_WIDTH=32) using a
// scoreboard queue of expected {overflow, product} values.
module tb_fixed_multiply;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] product;
  logic        overflow;
  logic        valid_out;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb_q[$];
  logic [32:0] held = 33'd0;

  fixed_multiply #(.Q_BITS(10), .D_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
    .ready_out(ready_out), .product(product), .overflow(overflow), .valid_out(valid_out)
  );

  always #5 clock = ~clock;

  // Reference: full 64-bit product, magnitude rounding, then saturation
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    longint p, mag, m;
    logic   neg;
    p   = longint'($signed(x)) * longint'($signed(y));
    neg = (p < 0);
    mag = neg ? -p : p;
    m   = (mag + 64'sd512) >>> 10;
    if (!neg) model = (m > 64'sd2147483647) ? {1'b1, 32'h7FFFFFFF} : {1'b0, m[31:0]};
    else      model = (m > 64'sd2147483648) ? {1'b1, 32'h80000000} : {1'b0, 32'(-m)};
  endfunction

  // Called at a negedge; presents one request for exactly one accept edge
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic [32:0] exp, input bit push);
    a = ta;
    b = tb;
    valid_in = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Waits for valid_out, pops the scoreboard and compares; can poke valid_in while busy
  task automatic wait_result(input int poke, output int lat, output int busy);
    logic [32:0] exp;
    bit          seen;
    seen = 1'b0;
    lat  = 0;
    busy = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (valid_out) begin
        seen = 1'b1;
      end else begin
        if (!ready_out) busy++;
        checks++;
        if ({overflow, product} !== held) begin
          errors++;
          $display("FAIL product_hold got %h/%b expected %h/%b", product, overflow, held[31:0], held[32]);
        end
        if (lat == poke) begin
          valid_in = 1'b1;
          a = $urandom;
          b = $urandom;
        end else begin
          valid_in = 1'b0;
        end
        lat++;
      end
    end
    valid_in = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL result_timeout got no valid_out expected one within 100 cycles");
    end else if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_result got %h/%b expected no result", product, overflow);
    end else begin
      exp = sb_q.pop_front();
      if ({overflow, product} !== exp) begin
        errors++;
        $display("FAIL result got product=%h overflow=%b expected product=%h overflow=%b",
                 product, overflow, exp[31:0], exp[32]);
      end
      held = {overflow, product};
      checks++;
      if (ready_out !== 1'b1) begin
        errors++;
        $display("FAIL ready_with_valid got %b expected 1", ready_out);
      end
    end
  endtask

  // Confirms no valid_out and continued readiness for n cycles
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
        errors++;
        $display("FAIL idle got valid_out=%b ready_out=%b expected 0/1", valid_out, ready_out);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({product, overflow, valid_out, ready_out} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got p=%h o=%b v=%b r=%b expected 0/0/0/1", product, overflow, valid_out, ready_out);
    end
    @(negedge clock);
    reset = 1'b0;
    held = 33'd0;
  endtask

  task automatic test_basic();
    int lat, busy;
    @(negedge clock);
    start_op(32'd1536, 32'd2048, {1'b0, 32'd3072}, 1'b1);
    wait_result(-1, lat, busy);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL latency got %0d expected 34", lat);
    end
    checks++;
    if (busy != 34) begin
      errors++;
      $display("FAIL busy_cycles got %0d expected 34", busy);
    end
  endtask

  task automatic test_table();
    int lat, busy;
    logic [31:0] ta[8];
    logic [31:0] tb[8];
    logic [32:0] te[8];
    ta = '{32'hFFFFFA00, 32'd0,       32'd1, 32'hFFFFFFFF, 32'd1,   32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    tb = '{32'd2048,     32'hFFFFEC78, 32'd512, 32'd512,   32'd511, 32'h7FFFFFFF, 32'd1024,     32'hFFFFFC00};
    te = '{{1'b0, 32'hFFFFF400}, {1'b0, 32'd0}, {1'b0, 32'd1}, {1'b0, 32'hFFFFFFFF}, {1'b0, 32'd0},
           {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h80000000}, {1'b1, 32'h7FFFFFFF}};
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      start_op(ta[i], tb[i], te[i], 1'b1);
      wait_result(-1, lat, busy);
    end
  endtask

  task automatic test_ignore_busy();
    int lat, busy;
    @(negedge clock);
    start_op(32'd1000, 32'd3000, {1'b0, 32'd2930}, 1'b1);
    wait_result(5, lat, busy);
    idle_check(40);
  endtask

  task automatic test_back_to_back();
    int lat, busy;
    @(negedge clock);
    start_op(32'd3072, 32'hFFFFF800, {1'b0, 32'hFFFFE800}, 1'b1);
    wait_result(-1, lat, busy);
    start_op(32'hFFFFE600, 32'hFFFFF400, {1'b0, 32'd19968}, 1'b1);
    wait_result(-1, lat, busy);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL b2b_latency got %0d expected 34", lat);
    end
  endtask

  task automatic test_reset_abort();
    int lat, busy;
    @(negedge clock);
    start_op(32'd5120, 32'd5120, 33'd0, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({product, overflow, valid_out, ready_out} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_state got p=%h o=%b v=%b r=%b expected 0/0/0/1", product, overflow, valid_out, ready_out);
    end
    held = 33'd0;
    @(negedge clock);
    reset = 1'b0;
    idle_check(40);
    @(negedge clock);
    start_op(32'd1536, 32'hFFFFF800, {1'b0, 32'hFFFFF400}, 1'b1);
    wait_result(-1, lat, busy);
  endtask

  task automatic test_random();
    int lat, busy;
    logic [31:0] x, y, r;
    for (int i = 0; i < 10; i++) begin
      r = $urandom;
      x = (i % 3 == 0) ? $urandom : {{16{r[15]}}, r[15:0]};
      r = $urandom;
      y = (i % 2 == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
      @(negedge clock);
      start_op(x, y, model(x, y), 1'b1);
      wait_result(-1, lat, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
